// File: rtl/adder_operand_pipe.sv
// adder_operand_pipe: registered valid/ready wrapper around an external
// combinational adder. Stage S1 holds the operand triple on the adder inputs.
// Stage S2 is a 2-entry in-order result FIFO (head register + tail register)
// whose head drives the output stream.
module adder_operand_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  // operand stream
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_carry_in,
  // adder side
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_carry_in,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_carry_out,
  // result stream
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry_out,
  output logic             out_overflow,
  output logic [CNT_W-1:0] txn_count
);

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
  } result_t;

  logic    s1_valid;
  logic    tail_valid;
  result_t head_q;
  result_t tail_q;
  result_t new_res;

  logic in_fire;
  logic pop;
  logic push;
  logic fifo_full;
  logic fifo_can_write;
  logic ovf;

  // Handshake and FIFO control. in_ready depends only on registered state and
  // out_ready, never on in_valid.
  assign pop            = out_valid && out_ready;
  assign fifo_full      = out_valid && tail_valid;
  assign fifo_can_write = !fifo_full || pop;
  assign push           = s1_valid && fifo_can_write;
  assign in_ready       = !s1_valid || fifo_can_write;
  assign in_fire        = in_valid && in_ready;

  // Signed overflow: operands agree in sign but the sum does not.
  assign ovf = (add_a[WIDTH-1] == add_b[WIDTH-1]) &&
               (add_sum[WIDTH-1] != add_a[WIDTH-1]);

  assign new_res = '{sum: add_sum, carry_out: add_carry_out, overflow: ovf};

  // S1 operand register; operands hold their last value while S1 is empty so
  // the adder inputs never toggle needlessly.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid     <= 1'b0;
      add_a        <= '0;
      add_b        <= '0;
      add_carry_in <= 1'b0;
    end else begin
      if (in_fire) begin
        add_a        <= in_a;
        add_b        <= in_b;
        add_carry_in <= in_carry_in;
        s1_valid     <= 1'b1;
      end else if (push) begin
        s1_valid     <= 1'b0;
      end
    end
  end

  // Result FIFO: head is the output register, tail is the second slot. On pop
  // the tail (if any) moves to the head; a simultaneous push refills behind it.
  // NOTE: the two FIFO slots are reset because the head is the visible output
  // and must read zero out of reset; this storage is tiny, unlike a RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      tail_valid <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      if (pop) begin
        if (tail_valid) begin
          head_q <= tail_q;
          if (push) begin
            tail_q <= new_res;
          end else begin
            tail_valid <= 1'b0;
          end
        end else if (push) begin
          head_q <= new_res;
        end else begin
          // head data is left in place: out_* keep the last popped result
          out_valid <= 1'b0;
        end
      end else if (push) begin
        if (out_valid) begin
          tail_q     <= new_res;
          tail_valid <= 1'b1;
        end else begin
          head_q    <= new_res;
          out_valid <= 1'b1;
        end
      end
    end
  end

  // Completed output handshakes, wrapping modulo 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_count <= '0;
    end else if (pop) begin
      txn_count <= txn_count + CNT_W'(1);
    end
  end

  assign out_sum       = head_q.sum;
  assign out_carry_out = head_q.carry_out;
  assign out_overflow  = head_q.overflow;

endmodule

// File: tb/tb_adder_operand_pipe.sv
// Self-checking bench for adder_operand_pipe. The external adder is modelled
// combinationally; expected results are queued when an operand handshake
// happens and compared when the matching output handshake happens.
module tb_adder_operand_pipe;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    exp_t        e;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, in_carry_in;
  logic [31:0] in_a, in_b;
  logic [31:0] add_a, add_b, add_sum;
  logic        add_carry_in, add_carry_out;
  logic        out_valid, out_ready, out_carry_out, out_overflow;
  logic [31:0] out_sum;
  logic [15:0] txn_count;

  // narrow instance used for counter wrap
  logic       w_in_valid, w_in_ready, w_in_carry_in;
  logic [7:0] w_in_a, w_in_b, w_add_a, w_add_b, w_add_sum, w_out_sum;
  logic       w_add_carry_in, w_add_carry_out;
  logic       w_out_valid, w_out_ready, w_out_carry_out, w_out_overflow;
  logic [3:0] w_txn_count;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   hs_count = 0;
  bit   rand_done;

  adder_operand_pipe #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_carry_in(in_carry_in),
    .add_a(add_a), .add_b(add_b), .add_carry_in(add_carry_in),
    .add_sum(add_sum), .add_carry_out(add_carry_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_carry_out(out_carry_out),
    .out_overflow(out_overflow), .txn_count(txn_count)
  );

  adder_operand_pipe #(.WIDTH(8), .CNT_W(4)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_a(w_in_a), .in_b(w_in_b), .in_carry_in(w_in_carry_in),
    .add_a(w_add_a), .add_b(w_add_b), .add_carry_in(w_add_carry_in),
    .add_sum(w_add_sum), .add_carry_out(w_add_carry_out),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_sum(w_out_sum), .out_carry_out(w_out_carry_out),
    .out_overflow(w_out_overflow), .txn_count(w_txn_count)
  );

  // combinational adders
  assign {add_carry_out, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'b0, add_carry_in};
  assign {w_add_carry_out, w_add_sum} = {1'b0, w_add_a} + {1'b0, w_add_b} + {8'b0, w_add_carry_in};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s", name);
  endtask

  function automatic exp_t mk(input logic [31:0] s, input logic c, input logic o);
    exp_t r;
    r.sum = s; r.cout = c; r.ovf = o;
    return r;
  endfunction

  // Reference: unsigned 33-bit sum for carry; overflow when the true signed
  // sum does not fit back into 32 bits.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic c);
    logic [32:0] u;
    longint      s;
    exp_t        r;
    u = {1'b0, a} + {1'b0, b} + {32'b0, c};
    s = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
    r.sum  = u[31:0];
    r.cout = u[32];
    r.ovf  = (s != longint'($signed(u[31:0])));
    return r;
  endfunction

  // Output monitor: the handshake seen at a negedge completes on the next edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      hs_count++;
      if (exp_q.size() == 0) begin
        fail("unexpected_output");
      end else begin
        mon_e = exp_q.pop_front();
        check("out_sum", 64'(out_sum), 64'(mon_e.sum));
        check("out_carry_out", 64'(out_carry_out), 64'(mon_e.cout));
        check("out_overflow", 64'(out_overflow), 64'(mon_e.ovf));
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic c, input exp_t e);
    in_valid = 1'b1; in_a = a; in_b = b; in_carry_in = c;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    fail("send_timeout");
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      @(posedge clk); #1;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Assert reset between edges, release on a negedge.
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    exp_q.delete();
    hs_count = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  vec_t vecs[8];
  int   stale;
  int   hsw;
  bit   fire;

  initial begin
    vecs[0] = '{a: 32'hFFFF_FFFF, b: 32'h0000_0000, cin: 1'b1, e: mk(32'h0000_0000, 1'b1, 1'b0)};
    vecs[1] = '{a: 32'h7FFF_FFFF, b: 32'h0000_0001, cin: 1'b0, e: mk(32'h8000_0000, 1'b0, 1'b1)};
    vecs[2] = '{a: 32'h8000_0000, b: 32'h8000_0000, cin: 1'b0, e: mk(32'h0000_0000, 1'b1, 1'b1)};
    vecs[3] = '{a: 32'h0000_0001, b: 32'h0000_0002, cin: 1'b0, e: mk(32'h0000_0003, 1'b0, 1'b0)};
    vecs[4] = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, cin: 1'b1, e: mk(32'hFFFF_FFFF, 1'b1, 1'b0)};
    vecs[5] = '{a: 32'h7FFF_FFFF, b: 32'h0000_0000, cin: 1'b1, e: mk(32'h8000_0000, 1'b0, 1'b1)};
    vecs[6] = '{a: 32'h8000_0000, b: 32'hFFFF_FFFF, cin: 1'b0, e: mk(32'h7FFF_FFFF, 1'b1, 1'b1)};
    vecs[7] = '{a: 32'h1234_5678, b: 32'h8765_4321, cin: 1'b0, e: mk(32'h9999_9999, 1'b0, 1'b0)};

    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_carry_in = 1'b0; out_ready = 1'b0;
    w_in_valid = 1'b0; w_in_a = '0; w_in_b = '0; w_in_carry_in = 1'b0; w_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // reset state
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_sum", 64'(out_sum), 64'd0);
    check("rst_out_carry", 64'(out_carry_out), 64'd0);
    check("rst_out_ovf", 64'(out_overflow), 64'd0);
    check("rst_txn", 64'(txn_count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_add_a", 64'(add_a), 64'd0);
    check("rst_add_b", 64'(add_b), 64'd0);
    check("rst_add_cin", 64'(add_carry_in), 64'd0);

    // single transaction latency
    in_valid = 1'b1; in_a = 32'hFFFF_FFFF; in_b = 32'h0; in_carry_in = 1'b1;
    @(negedge clk);
    check("lat_in_ready", 64'(in_ready), 64'd1);
    exp_q.push_back(mk(32'h0, 1'b1, 1'b0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("lat_add_a", 64'(add_a), 64'hFFFF_FFFF);
    check("lat_add_cin", 64'(add_carry_in), 64'd1);
    check("lat_valid_e0", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_valid_e1", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("lat_txn", 64'(txn_count), 64'd1);
    check("lat_valid_after_pop", 64'(out_valid), 64'd0);

    // directed vector table, back-to-back
    for (int i = 0; i < 8; i++) send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].e);
    drain();
    check("table_txn", 64'(txn_count), 64'd9);

    // backpressure: three fit, fourth stalls
    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) send(32'(k), 32'(k), 1'b0, mk(32'(2 * k), 1'b0, 1'b0));
    in_valid = 1'b1; in_a = 32'd4; in_b = 32'd4; in_carry_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_head_stable", 64'(out_sum), 64'd2);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(32'd4, 32'd4, 1'b0, mk(32'd8, 1'b0, 1'b0));
    drain();
    check("bp_txn", 64'(txn_count), 64'd13);

    // random traffic with toggling out_ready, from a clean reset
    pulse_reset();
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          logic [31:0] ra, rb;
          logic        rc;
          ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
          if (i % 10 == 0) ra = 32'h7FFF_FFFF;
          if (i % 10 == 5) rb = 32'h8000_0000;
          if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
          send(ra, rb, rc, model(ra, rb, rc));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();
    check("rand_txn", 64'(txn_count), 64'd100);
    check("rand_hs", 64'(hs_count), 64'd100);

    // reset with three entries in flight
    out_ready = 1'b0;
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, mk(32'hFFFF_FFFE, 1'b1, 1'b0));
    send(32'h7FFF_FFFF, 32'h1, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1));
    send(32'd10, 32'd10, 1'b0, mk(32'd20, 1'b0, 1'b0));
    #2 rst_n = 1'b0;
    #1;
    check("mr_out_valid", 64'(out_valid), 64'd0);
    check("mr_out_sum", 64'(out_sum), 64'd0);
    check("mr_out_carry", 64'(out_carry_out), 64'd0);
    check("mr_out_ovf", 64'(out_overflow), 64'd0);
    check("mr_txn", 64'(txn_count), 64'd0);
    check("mr_add_a", 64'(add_a), 64'd0);
    check("mr_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    hs_count = 0;
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("mr_no_stale", 64'(stale), 64'd0);
    check("mr_in_ready_after", 64'(in_ready), 64'd1);

    // counter wrap on the narrow instance
    @(posedge clk); #1;
    w_in_valid = 1'b1; w_in_a = 8'h21; w_in_b = 8'h12; w_in_carry_in = 1'b0;
    hsw = 0;
    for (int cyc = 0; cyc < 60 && hsw < 17; cyc++) begin
      @(negedge clk);
      fire = w_out_valid && w_out_ready;
      if (fire) hsw++;
      @(posedge clk); #1;
      if (fire) check("wrap_txn", 64'(w_txn_count), 64'(hsw % 16));
    end
    w_in_valid = 1'b0;
    check("wrap_hs_count", 64'(hsw), 64'd17);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

endmodule
